// File: rtl/stream_byte_packer_pkg.sv
// Shared sizing for the byte-stream to word-stream path (skid_buffer, packer, word datapath).
package stream_byte_packer_pkg;

   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int DEF_DATA_W         = 8;
   localparam int DEF_BYTES_PER_WORD = 4;
   localparam int WORD_W             = DEF_DATA_W * DEF_BYTES_PER_WORD;
   localparam int CNT_W              = cnt_width(DEF_BYTES_PER_WORD);

endpackage

// File: rtl/stream_word_reg.sv
// Output holding register for packed words with a valid/ready handshake toward the word datapath.
module stream_word_reg #(
   parameter int WORD_W = 32,
   parameter int KEEP_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_i,
   input  logic [WORD_W-1:0] data_i,
   input  logic [KEEP_W-1:0] keep_i,
   input  logic              last_i,
   output logic              can_load_o,
   output logic              e_valid_o,
   output logic [WORD_W-1:0] e_data_o,
   output logic [KEEP_W-1:0] e_keep_o,
   output logic              e_last_o,
   input  logic              e_ready_i
);

   logic              valid_q, valid_d;
   logic [WORD_W-1:0] data_q, data_d;
   logic [KEEP_W-1:0] keep_q, keep_d;
   logic              last_q, last_d;

   // A new word may enter when the slot is empty or is being drained this cycle.
   assign can_load_o = !valid_q || e_ready_i;

   // Next-state: a load replaces the held word; a plain drain only clears valid.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      keep_d  = keep_q;
      last_d  = last_q;
      if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
         keep_d  = keep_i;
         last_d  = last_i;
      end else if (valid_q && e_ready_i) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // State registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         keep_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         keep_q  <= keep_d;
         last_q  <= last_d;
      end
   end

   assign e_valid_o = valid_q;
   assign e_data_o  = data_q;
   assign e_keep_o  = keep_q;
   assign e_last_o  = last_q;

endmodule

// File: rtl/stream_byte_packer.sv
// Packs a valid/ready byte stream into LSB-first words with keep and end-of-packet flags.
module stream_byte_packer
   import stream_byte_packer_pkg::*;
#(
   parameter int DATA_W         = DEF_DATA_W,
   parameter int BYTES_PER_WORD = DEF_BYTES_PER_WORD
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             i_valid_i,
   input  logic [DATA_W-1:0]                i_data_i,
   input  logic                             i_last_i,
   output logic                             i_ready_o,
   output logic                             e_valid_o,
   output logic [DATA_W*BYTES_PER_WORD-1:0] e_data_o,
   output logic [BYTES_PER_WORD-1:0]        e_keep_o,
   output logic                             e_last_o,
   input  logic                             e_ready_i
);

   localparam int OUT_W = DATA_W * BYTES_PER_WORD;
   localparam int CW    = cnt_width(BYTES_PER_WORD);
   localparam logic [CW-1:0] LAST_CNT = CW'(BYTES_PER_WORD - 1);

   logic                      can_load_s;
   logic                      in_fire_s;
   logic                      complete_s;
   logic [OUT_W-1:0]          acc_q, acc_d;
   logic [OUT_W-1:0]          word_s;
   logic [CW-1:0]             cnt_q, cnt_d;
   logic [BYTES_PER_WORD-1:0] keep_s;

   assign i_ready_o  = !reset && can_load_s;
   assign in_fire_s  = i_valid_i && i_ready_o;
   assign complete_s = in_fire_s && ((cnt_q == LAST_CNT) || i_last_i);

   // Lanes above the current one are already zero because completion clears the accumulator.
   always_comb begin
      word_s = acc_q;
      word_s[cnt_q*DATA_W +: DATA_W] = i_data_i;
      keep_s = '0;
      for (int k = 0; k < BYTES_PER_WORD; k++) begin
         keep_s[k] = (CW'(k) <= cnt_q);
      end
      acc_d = acc_q;
      cnt_d = cnt_q;
      if (complete_s) begin
         acc_d = '0;
         cnt_d = '0;
      end else if (in_fire_s) begin
         acc_d = word_s;
         cnt_d = cnt_q + CW'(1);
      end else begin
         acc_d = acc_q;
         cnt_d = cnt_q;
      end
   end

   // Accumulator and lane counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q <= '0;
         cnt_q <= '0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
      end
   end

   stream_word_reg #(
      .WORD_W (OUT_W),
      .KEEP_W (BYTES_PER_WORD)
   ) u_word_reg (
      .clk        (clk),
      .reset      (reset),
      .load_i     (complete_s),
      .data_i     (word_s),
      .keep_i     (keep_s),
      .last_i     (i_last_i),
      .can_load_o (can_load_s),
      .e_valid_o  (e_valid_o),
      .e_data_o   (e_data_o),
      .e_keep_o   (e_keep_o),
      .e_last_o   (e_last_o),
      .e_ready_i  (e_ready_i)
   );

endmodule

// File: tb/tb_stream_byte_packer.sv
// Directed table-driven bench for stream_byte_packer plus hand-written multi-cycle sequences.
module tb_stream_byte_packer;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_valid_i;
   logic [7:0]  i_data_i;
   logic        i_last_i;
   logic        i_ready_o;
   logic        e_valid_o;
   logic [31:0] e_data_o;
   logic [3:0]  e_keep_o;
   logic        e_last_o;
   logic        e_ready_i;

   int tests = 0;
   int fails = 0;

   stream_byte_packer #(.DATA_W(8), .BYTES_PER_WORD(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .i_valid_i (i_valid_i),
      .i_data_i  (i_data_i),
      .i_last_i  (i_last_i),
      .i_ready_o (i_ready_o),
      .e_valid_o (e_valid_o),
      .e_data_o  (e_data_o),
      .e_keep_o  (e_keep_o),
      .e_last_o  (e_last_o),
      .e_ready_i (e_ready_i)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        v;
      logic [7:0]  d;
      logic        l;
      logic        er;
      logic        x_ir;
      logic        x_ev;
      logic [31:0] x_d;
      logic [3:0]  x_k;
      logic        x_el;
      logic        chk;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rst, input logic v, input logic [7:0] d, input logic l,
                      input logic er, input logic x_ir, input logic x_ev, input logic [31:0] x_d,
                      input logic [3:0] x_k, input logic x_el, input logic chk);
      vec_t t;
      t.rst = rst; t.v = v; t.d = d; t.l = l; t.er = er;
      t.x_ir = x_ir; t.x_ev = x_ev; t.x_d = x_d; t.x_k = x_k; t.x_el = x_el; t.chk = chk;
      vecs.push_back(t);
   endtask

   task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   initial begin
      reset = 1'b1; i_valid_i = 1'b0; i_data_i = 8'h00; i_last_i = 1'b0; e_ready_i = 1'b1;

      // full word, single-cycle valid
      add(1'b1, 1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1);
      add(1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
      add(1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
      add(1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
      add(1'b0, 1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
      add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 32'h44332211, 4'hF, 1'b0, 1'b1);
      add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
      // partial words flushed by last, including word replacement on the same edge as a drain
      add(1'b0, 1'b1, 8'hAA, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
      add(1'b0, 1'b1, 8'hBB, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
      add(1'b0, 1'b1, 8'hCC, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000BBAA, 4'h3, 1'b1, 1'b1);
      add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 32'h000000CC, 4'h1, 1'b1, 1'b1);
      add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
      // backpressure for five cycles while upstream offers a byte that must not be taken
      add(1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
      add(1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
      add(1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
      add(1'b0, 1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++)
         add(1'b0, 1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 1'b1, 32'h44332211, 4'hF, 1'b0, 1'b1);
      add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 32'h44332211, 4'hF, 1'b0, 1'b1);
      add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
      // eight bytes back to back
      add(1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
      add(1'b0, 1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
      add(1'b0, 1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
      add(1'b0, 1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
      add(1'b0, 1'b1, 8'h05, 1'b0, 1'b1, 1'b1, 1'b1, 32'h04030201, 4'hF, 1'b0, 1'b1);
      add(1'b0, 1'b1, 8'h06, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
      add(1'b0, 1'b1, 8'h07, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
      add(1'b0, 1'b1, 8'h08, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
      add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 32'h08070605, 4'hF, 1'b0, 1'b1);
      add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
      // reset discards a partial word
      add(1'b0, 1'b1, 8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
      add(1'b0, 1'b1, 8'h66, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
      add(1'b1, 1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1);
      add(1'b1, 1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1);
      add(1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
      add(1'b0, 1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
      add(1'b0, 1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
      add(1'b0, 1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
      add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 32'h04030201, 4'hF, 1'b0, 1'b1);
      add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);

      @(posedge clk); #1;
      for (int i = 0; i < vecs.size(); i++) begin
         reset = vecs[i].rst; i_valid_i = vecs[i].v; i_data_i = vecs[i].d;
         i_last_i = vecs[i].l; e_ready_i = vecs[i].er;
         @(negedge clk);
         check("i_ready", i, {31'b0, i_ready_o}, {31'b0, vecs[i].x_ir});
         check("e_valid", i, {31'b0, e_valid_o}, {31'b0, vecs[i].x_ev});
         if (vecs[i].chk) begin
            check("e_data", i, e_data_o, vecs[i].x_d);
            check("e_keep", i, {28'b0, e_keep_o}, {28'b0, vecs[i].x_k});
            check("e_last", i, {31'b0, e_last_o}, {31'b0, vecs[i].x_el});
         end
         @(posedge clk); #1;
      end

      // partial word survives a long idle gap, then a last byte flushes it
      reset = 1'b0; e_ready_i = 1'b1; i_valid_i = 1'b1; i_data_i = 8'h12; i_last_i = 1'b0;
      @(posedge clk); #1;
      i_valid_i = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("idle_no_flush", 100, {31'b0, e_valid_o}, 32'h0);
      @(posedge clk); #1;
      i_valid_i = 1'b1; i_data_i = 8'h34; i_last_i = 1'b1;
      @(posedge clk); #1;
      i_valid_i = 1'b0; i_last_i = 1'b0;
      @(negedge clk);
      check("idle_valid", 101, {31'b0, e_valid_o}, 32'h1);
      check("idle_data", 101, e_data_o, 32'h00003412);
      check("idle_keep", 101, {28'b0, e_keep_o}, 32'h3);
      check("idle_last", 101, {31'b0, e_last_o}, 32'h1);

      // asynchronous reset while a word is stalled at the output
      @(posedge clk); #1;
      e_ready_i = 1'b0; i_valid_i = 1'b1;
      for (int b = 0; b < 4; b++) begin
         i_data_i = 8'hA1 + 8'(b);
         @(posedge clk); #1;
      end
      @(negedge clk);
      check("stall_valid", 102, {31'b0, e_valid_o}, 32'h1);
      check("stall_ready", 102, {31'b0, i_ready_o}, 32'h0);
      check("stall_data", 102, e_data_o, 32'hA4A3A2A1);
      #2 reset = 1'b1;
      #1;
      check("arst_valid", 103, {31'b0, e_valid_o}, 32'h0);
      check("arst_data", 103, e_data_o, 32'h0);
      check("arst_keep", 103, {28'b0, e_keep_o}, 32'h0);
      check("arst_ready", 103, {31'b0, i_ready_o}, 32'h0);
      @(posedge clk); #1;
      reset = 1'b0; i_valid_i = 1'b0; e_ready_i = 1'b1;
      @(negedge clk);
      check("post_ready", 104, {31'b0, i_ready_o}, 32'h1);
      check("post_valid", 104, {31'b0, e_valid_o}, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/stream_byte_packer.md
Name: stream_byte_packer

Overview:
- Sits directly downstream of skid_buffer.
- Consumes its 8-bit valid/ready byte stream and packs consecutive bytes into 32-bit words.
- Each word carries per-byte keep flags and an end-of-packet marker, for the wider datapath that follows.
- A packet end flagged by i_last_i flushes a partially filled word immediately.

Parameters:
- DATA_W, 8, width of one input byte lane.
- BYTES_PER_WORD, 4, input beats packed per output word; output width is DATA_W*BYTES_PER_WORD.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- i_valid_i  input  1  upstream byte valid (from skid_buffer e_valid_o).
- i_data_i  input  DATA_W  upstream byte.
- i_last_i  input  1  byte is the final byte of a packet.
- i_ready_o  output  1  packer can accept a byte this cycle.
- e_valid_o  output  1  packed word valid.
- e_data_o  output  DATA_W*BYTES_PER_WORD  packed word.
- e_keep_o  output  BYTES_PER_WORD  one bit per populated byte lane.
- e_last_o  output  1  word closes a packet.
- e_ready_i  input  1  downstream accepts word.

Behaviour:
- Reset (async assert, sync-to-clk deassert handled externally):
  - e_valid_o=0, e_data_o=0, e_keep_o=0, e_last_o=0.
  - Byte counter=0, accumulator=0.
  - i_ready_o forced 0 while reset is high.
- Transfers: input transfer = i_valid_i && i_ready_o; output transfer = e_valid_o && e_ready_i.
- i_ready_o = !reset && (!e_valid_o || e_ready_i).
  - This is a combinational path from e_ready_i.
  - Any downstream timing break is done by a skid_buffer on the output, not inside this block.
- Lane order: byte k of a word (k = counter value at acceptance) lands in bits [k*DATA_W +: DATA_W]. First byte goes to the LSB lane.
- Non-completing byte (counter < BYTES_PER_WORD-1 and i_last_i=0):
  - Written to lane k of the accumulator; counter increments.
  - Output register unchanged.
- Completing byte (counter == BYTES_PER_WORD-1, or i_last_i=1):
  - Output register loads the accumulator with byte inserted at lane k.
  - Unpopulated lanes are zero.
  - e_keep_o = (1<<(k+1))-1; e_last_o = i_last_i; e_valid_o=1.
  - Accumulator and counter clear to 0 in the same cycle.
- Latency: word visible on e_* the cycle after its completing byte is accepted.
- Throughput: one byte per cycle sustained while e_ready_i=1. Back-to-back words are emitted on consecutive word boundaries with no bubble.
- Output transfer without a simultaneous new word: e_valid_o drops to 0. e_data_o/e_keep_o/e_last_o hold their last values (don't-care when invalid).
- Simultaneous output transfer and completing byte: the new word replaces the old one; e_valid_o stays 1.
- Backpressure (e_valid_o=1, e_ready_i=0):
  - e_data_o/e_keep_o/e_last_o are held stable.
  - i_ready_o=0 and no input is consumed; the accumulator is frozen.
- i_valid_i=0 with a partial word: the accumulator holds indefinitely. There is no timeout flush.
- Reset mid-word or mid-output: the partial accumulator and any pending output word are discarded. The next accepted byte starts lane 0.
- Counter width: $clog2(BYTES_PER_WORD), minimum 1. No wrap beyond BYTES_PER_WORD-1, because completion clears it.

Decomposition:
- Shared package: DATA_W and BYTES_PER_WORD defaults, and derived localparams WORD_W and CNT_W. Share with skid_buffer and the downstream word path.
- Single sub-module is natural: stream_word_reg, the output holding register with valid/ready.
- Byte accumulation and counter stay in the top module.

Test Plan:
- Bytes 0x11,0x22,0x33,0x44 on consecutive cycles, e_ready_i=1, i_last_i=0.
  - Expect e_data_o=0x44332211, e_keep_o=0xF, e_last_o=0, e_valid_o high for exactly one cycle, one cycle after 0x44 is accepted.
- Bytes 0xAA, then 0xBB with i_last_i=1.
  - Expect e_data_o=0x0000BBAA, e_keep_o=0x3, e_last_o=1.
  - A following byte 0xCC with last gives 0x000000CC, keep 0x1, last 1.
- Word 0x44332211 pending with e_ready_i=0 for 5 cycles.
  - Expect e_data_o stable and i_ready_o=0 throughout.
  - Raising e_ready_i gives a transfer, then i_ready_o=1 in the same cycle.
- Eight bytes 0x01..0x08 back-to-back, e_ready_i=1.
  - Expect i_ready_o never low, words 0x04030201 and 0x08070605 four cycles apart, both keep 0xF.
- Accept 0x55,0x66, assert reset for 2 cycles, then send 0x01..0x04.
  - Expect all outputs 0 during reset and a single word 0x04030201, keep 0xF, with no 0x55/0x66 leakage.
